axi_bridge_wb: RTL and testbench
================================

Name: axi_bridge_wb

Overview:
Next-generation cache-to-AXI bridge that serves one icache read port and one dcache read/write port over a single AXI3-style master interface. Unlike the previous bridge, dcache writes go into a real WB_DEPTH-entry write buffer instead of blocking the dcache until each write completes. Line length is parametrised. Reads that hit a buffered write are held until that write drains (read-after-write protection). Sits between the L1 caches and the SoC AXI interconnect.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; power of two, 1..16; line transfers use arlen/awlen = LINE_WORDS-1.
WB_DEPTH, 4, write-buffer entries; power of two, 2..8.
LINE_OFFSET_BITS, log2(LINE_WORDS*4), byte-offset bits ignored by the address match.

Ports:
clock  input  1  system clock; everything is rising-edge.
reset  input  1  asynchronous, active-high reset.
arvalid/arready/arid[3:0]/araddr[31:0]/arlen[7:0]/arsize[2:0]  mixed  -  AXI AR channel.
rvalid/rready/rid[3:0]/rdata[31:0]/rresp[1:0]/rlast  mixed  -  AXI R channel; rready tied to 1.
awvalid/awready/awaddr[31:0]/awlen[7:0]/awsize[2:0]  mixed  -  AXI AW channel.
wvalid/wready/wlast/wdata[31:0]/wstrb[3:0]  mixed  -  AXI W channel.
bvalid/bready/bid[3:0]/bresp[1:0]  mixed  -  AXI B channel.
arburst/awburst=01, arlock/awlock=00, arcache/awcache=0000, arprot/awprot=000, awid/wid=1  output  -  fixed constants.
i_rd_req/i_rd_type[2:0]/i_rd_addr[31:0]  input  -  icache read request; type 100 means a line.
i_rd_rdy  output  1  icache request accepted this cycle.
i_ret_valid/i_ret_last/i_ret_data[31:0]  output  -  icache return data.
d_rd_req/d_rd_type[2:0]/d_rd_addr[31:0]  input  -  dcache read request.
d_rd_rdy/d_ret_valid/d_ret_last/d_ret_data[31:0]  output  -  dcache read accept and return data.
d_wr_req/d_wr_type[2:0]/d_wr_addr[31:0]/d_wr_wstrb[3:0]  input  -  dcache write request.
d_wr_data  input  32*LINE_WORDS  write data; word 0 occupies the low 32 bits.
d_wr_rdy  output  1  write buffer is not full.
write_buffer_empty  output  1  buffer is empty and no write is in flight.

Behaviour:
- Reset: async. All valid signals, bready, *_rdy and ret_valid drop to 0; arid, araddr, arlen, arsize, awaddr, awlen and awsize go to 0. Buffer empties (head = tail = 0, count = 0). Write FSM returns to W_IDLE. write_buffer_empty = 1. Reset mid-burst discards all buffered and in-flight data.
- Write enqueue: a write is accepted when d_wr_req && d_wr_rdy, with d_wr_rdy = (count != WB_DEPTH). The entry stored is {addr, len, size, wstrb, data}.
  - Line (type 100): len = LINE_WORDS-1, size = 010.
  - Otherwise: len = 0, size = type.
- Write FSM (pops from head):
  - W_IDLE: when count > 0, go to W_AW and assert awvalid with the head entry's fields.
  - W_AW: on awready, drop awvalid, clear beat counter, assert wvalid, go to W_DATA.
  - W_DATA: wdata = head word[beat]. wstrb = entry wstrb for single transfers, 1111 for lines. wlast when beat == len. Each wready advances beat; a wready on the last beat drops wvalid, raises bready and goes to W_B.
  - W_B: on bvalid, drop bready, pop head (count-1), return to W_IDLE.
  - Unused state codes go to W_IDLE.
- Simultaneous enqueue and pop: count stays the same. A full buffer with a same-cycle pop still reports d_wr_rdy = 0 that cycle; this is registered and conservative.
- RAW hazard: a read is blocked when its address bits [31:LINE_OFFSET_BITS] equal those of any valid buffer entry, including the head in flight. A blocked read gets rd_rdy = 0. A write enqueued in the same cycle as the hazard check also counts.
- Read arbitration: dcache has fixed priority over icache. i_rd_rdy = recv && !d_rd_req; d_rd_rdy = recv && d_rd_req.
  - recv requires no hazard for the selected requester, and (AR idle, or arvalid && arready this cycle).
  - A dcache read under hazard does not let the icache pass in the same cycle.
  - arid = 1 for dcache, 0 for icache. arlen/arsize follow the same type rule as writes. AR fields are registered; arvalid holds until arready. Back-to-back issue is allowed on the arready cycle.
- Return: i_ret_valid = rvalid && rid != 1; d_ret_valid = rvalid && rid == 1. Last and data signals are passed straight from rlast and rdata.
- write_buffer_empty = (count == 0) && W_IDLE.

Test Plan:
- Reset, then 5 line writes (LINE_WORDS=4, WB_DEPTH=4) with awready/wready/bvalid held low -> first 4 accepted, d_wr_rdy = 0 on the 5th; after releasing the slave, 4 bursts of 4 beats in FIFO order, wlast on beat 3, write_buffer_empty = 1 afterwards.
- Buffered write to 0x1000_0040, then d_rd_req line to 0x1000_0048 -> d_rd_rdy stays 0 until bvalid pops the entry, then AR issues with araddr = 0x1000_0048, arlen = 3, arid = 1.
- d_rd_req and i_rd_req in the same cycle, no hazard -> dcache granted (arid = 1), icache granted on the next arready (arid = 0).
- Byte write (type 000, wstrb 0010) -> awlen = 0, awsize = 000, a single beat with wlast = 1 and wstrb = 0010.
- R beats with rid = 0 and rid = 1 interleaved -> i_ret_valid and d_ret_valid routed per beat, rlast propagated.
- Assert reset during W_DATA beat 2 -> wvalid = 0 immediately, count = 0, write_buffer_empty = 1.

Source files
------------

// File: rtl/axi_bridge_wb.sv
// Cache-to-AXI bridge: icache/dcache reads share one AR channel, dcache writes drain
// through a WB_DEPTH-entry FIFO; reads to a line still held in the FIFO are stalled.
module axi_bridge_wb #(
    parameter int LINE_WORDS       = 4,
    parameter int WB_DEPTH         = 4,
    parameter int LINE_OFFSET_BITS = $clog2(LINE_WORDS * 4)
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [3:0]              wid,
    output logic                    wlast,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    i_rd_req,
    input  logic [2:0]              i_rd_type,
    input  logic [31:0]             i_rd_addr,
    output logic                    i_rd_rdy,
    output logic                    i_ret_valid,
    output logic                    i_ret_last,
    output logic [31:0]             i_ret_data,
    input  logic                    d_rd_req,
    input  logic [2:0]              d_rd_type,
    input  logic [31:0]             d_rd_addr,
    output logic                    d_rd_rdy,
    output logic                    d_ret_valid,
    output logic                    d_ret_last,
    output logic [31:0]             d_ret_data,
    input  logic                    d_wr_req,
    input  logic [2:0]              d_wr_type,
    input  logic [31:0]             d_wr_addr,
    input  logic [3:0]              d_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] d_wr_data,
    output logic                    d_wr_rdy,
    output logic                    write_buffer_empty
);
    localparam int IDX_W  = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W  = $clog2(WB_DEPTH) + 1;
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [7:0]       LINE_LEN = 8'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(WB_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wstate_t;

    function automatic logic [7:0] type_len(input logic [2:0] t);
        return (t == 3'b100) ? LINE_LEN : 8'd0;
    endfunction

    function automatic logic [2:0] type_size(input logic [2:0] t);
        return (t == 3'b100) ? 3'b010 : t;
    endfunction

    logic [31:0]             wb_addr [WB_DEPTH];
    logic [7:0]              wb_len  [WB_DEPTH];
    logic [2:0]              wb_size [WB_DEPTH];
    logic [3:0]              wb_strb [WB_DEPTH];
    logic [32*LINE_WORDS-1:0] wb_data [WB_DEPTH];

    logic [WB_DEPTH-1:0] wb_valid_q, wb_valid_d;
    logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    wstate_t           wstate_q;
    logic              awvalid_q, wvalid_q, bready_q;
    logic [31:0]       awaddr_q;
    logic [7:0]        awlen_q;
    logic [2:0]        awsize_q;
    logic [BEAT_W-1:0] beat_q;

    logic        arvalid_q;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [2:0]  arsize_q;

    logic enq, pop;
    logic d_haz, i_haz, ar_free, recv;
    logic [WB_DEPTH-1:0] d_hit_vec, i_hit_vec;

    assign d_wr_rdy = !reset && (count_q != FULL);
    assign enq      = d_wr_req && d_wr_rdy;
    assign pop      = (wstate_q == W_B) && bvalid;

    always_ff @(posedge clock) begin
        if (enq) begin
            wb_addr[tail_q] <= d_wr_addr;
            wb_len[tail_q]  <= type_len(d_wr_type);
            wb_size[tail_q] <= type_size(d_wr_type);
            wb_strb[tail_q] <= (d_wr_type == 3'b100) ? 4'hf : d_wr_wstrb;
            wb_data[tail_q] <= d_wr_data;
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wb_valid_d = wb_valid_q;
        if (enq) begin
            tail_d             = tail_q + IDX_W'(1);
            wb_valid_d[tail_q] = 1'b1;
        end
        if (pop) begin
            head_d             = head_q + IDX_W'(1);
            wb_valid_d[head_q] = 1'b0;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wb_valid_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    // The head entry keeps its valid bit until its B response, so in-flight writes still block reads.
    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_raw
        assign d_hit_vec[gi] = wb_valid_q[gi] &&
            (wb_addr[gi][31:LINE_OFFSET_BITS] == d_rd_addr[31:LINE_OFFSET_BITS]);
        assign i_hit_vec[gi] = wb_valid_q[gi] &&
            (wb_addr[gi][31:LINE_OFFSET_BITS] == i_rd_addr[31:LINE_OFFSET_BITS]);
    end

    assign d_haz = (|d_hit_vec) ||
        (enq && (d_wr_addr[31:LINE_OFFSET_BITS] == d_rd_addr[31:LINE_OFFSET_BITS]));
    assign i_haz = (|i_hit_vec) ||
        (enq && (d_wr_addr[31:LINE_OFFSET_BITS] == i_rd_addr[31:LINE_OFFSET_BITS]));

    assign ar_free  = !arvalid_q || arready;
    assign recv     = !reset && ar_free && !(d_rd_req ? d_haz : i_haz);
    assign i_rd_rdy = recv && !d_rd_req;
    assign d_rd_rdy = recv && d_rd_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
        end else if (d_rd_rdy) begin
            arvalid_q <= 1'b1;
            arid_q    <= 4'd1;
            araddr_q  <= d_rd_addr;
            arlen_q   <= type_len(d_rd_type);
            arsize_q  <= type_size(d_rd_type);
        end else if (i_rd_req && i_rd_rdy) begin
            arvalid_q <= 1'b1;
            arid_q    <= 4'd0;
            araddr_q  <= i_rd_addr;
            arlen_q   <= type_len(i_rd_type);
            arsize_q  <= type_size(i_rd_type);
        end else if (arready) begin
            arvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            beat_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: if (count_q != '0) begin
                    wstate_q  <= W_AW;
                    awvalid_q <= 1'b1;
                    awaddr_q  <= wb_addr[head_q];
                    awlen_q   <= wb_len[head_q];
                    awsize_q  <= wb_size[head_q];
                end
                W_AW: if (awready) begin
                    wstate_q  <= W_DATA;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    beat_q    <= '0;
                end
                W_DATA: if (wready) begin
                    if (8'(beat_q) == awlen_q) begin
                        wstate_q <= W_B;
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                W_B: if (bvalid) begin
                    wstate_q <= W_IDLE;
                    bready_q <= 1'b0;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    logic [32*LINE_WORDS-1:0] head_line;
    logic [31:0]              head_words [LINE_WORDS];
    assign head_line = wb_data[head_q];
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
        assign head_words[gi] = head_line[gi*32 +: 32];
    end

    assign wdata   = head_words[beat_q];
    assign wstrb   = wb_strb[head_q];
    assign wlast   = wvalid_q && (8'(beat_q) == awlen_q);
    assign wvalid  = wvalid_q;
    assign awvalid = awvalid_q;
    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign bready  = bready_q;

    assign arvalid = arvalid_q;
    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;

    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'b0000;
    assign awcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awprot  = 3'b000;
    assign awid    = 4'd1;
    assign wid     = 4'd1;
    assign rready  = 1'b1;

    assign i_ret_valid = !reset && rvalid && (rid != 4'd1);
    assign d_ret_valid = !reset && rvalid && (rid == 4'd1);
    assign i_ret_last  = rlast;
    assign d_ret_last  = rlast;
    assign i_ret_data  = rdata;
    assign d_ret_data  = rdata;

    assign write_buffer_empty = (count_q == '0) && (wstate_q == W_IDLE);

    logic unused_ok;
    assign unused_ok = ^{rresp, bid, bresp};
endmodule

// File: tb/tb_axi_bridge_wb.sv
// Bench for axi_bridge_wb: directed scenarios plus a transaction-level model checked every cycle.
module tb_axi_bridge_wb;
    localparam int LW    = 4;
    localparam int DEPTH = 4;
    localparam int LOB   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  arid, rid, awid, wid, bid, wstrb, arcache, awcache, d_wr_wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata, i_rd_addr, d_rd_addr, d_wr_addr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot, i_rd_type, d_rd_type, d_wr_type;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
    logic        d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last;
    logic        d_wr_req, d_wr_rdy, write_buffer_empty;
    logic [31:0] i_ret_data, d_ret_data;
    logic [LW*32-1:0] d_wr_data;

    axi_bridge_wb #(.LINE_WORDS(LW), .WB_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .write_buffer_empty(write_buffer_empty)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: writes accepted but not yet acknowledged, and reads granted but not yet issued.
    logic [31:0]      m_waddr [$];
    logic [7:0]       m_wlen  [$];
    logic [2:0]       m_wsize [$];
    logic [3:0]       m_wstrb [$];
    logic [LW*32-1:0] m_wdata [$];
    logic [3:0]       m_arid  [$];
    logic [31:0]      m_araddr[$];
    logic [7:0]       m_arlen [$];
    logic [2:0]       m_arsize[$];
    int m_beat = 0, n_aw = 0, n_w = 0, n_b = 0;

    function automatic bit hazard(input logic [31:0] a, input bit enq_now);
        logic [31:0] t;
        for (int k = 0; k < m_waddr.size(); k++) begin
            t = m_waddr[k];
            if (t[31:LOB] == a[31:LOB]) return 1'b1;
        end
        t = d_wr_addr;
        return enq_now && (t[31:LOB] == a[31:LOB]);
    endfunction

    task automatic compare_cycle();
        logic [LW*32-1:0] line;
        logic [31:0]      exp_word;
        bit enq_exp, ar_free, exp_drdy, exp_irdy;
        enq_exp  = d_wr_req && (m_waddr.size() != DEPTH);
        ar_free  = (m_arid.size() == 0) || arready;
        exp_drdy = d_rd_req && ar_free && !hazard(d_rd_addr, enq_exp);
        exp_irdy = !d_rd_req && ar_free && !hazard(i_rd_addr, enq_exp);

        chk("write_buffer_empty", write_buffer_empty, 32'(m_waddr.size() == 0));
        chk("d_wr_rdy", d_wr_rdy, 32'(m_waddr.size() != DEPTH));
        chk("d_rd_rdy", d_rd_rdy, 32'(exp_drdy));
        chk("i_rd_rdy", i_rd_rdy, 32'(exp_irdy));
        chk("arvalid", arvalid, 32'(m_arid.size() != 0));
        chk("i_ret_valid", i_ret_valid, 32'(rvalid && (rid != 4'd1)));
        chk("d_ret_valid", d_ret_valid, 32'(rvalid && (rid == 4'd1)));
        if (rvalid) begin
            chk("ret_data", (rid == 4'd1) ? d_ret_data : i_ret_data, rdata);
            chk("ret_last", (rid == 4'd1) ? d_ret_last : i_ret_last, 32'(rlast));
        end

        if (m_waddr.size() == 0) begin
            chk("awvalid_idle", awvalid, 0);
            chk("wvalid_idle", wvalid, 0);
        end else begin
            if (awvalid && awready) begin
                chk("awaddr", awaddr, m_waddr[0]);
                chk("awlen", awlen, m_wlen[0]);
                chk("awsize", awsize, m_wsize[0]);
                n_aw++;
                $display("AW addr=%h len=%0d size=%0d", awaddr, awlen, awsize);
            end
            if (wvalid && wready) begin
                line     = m_wdata[0];
                exp_word = line[m_beat*32 +: 32];
                chk("wdata", wdata, exp_word);
                chk("wstrb", wstrb, m_wstrb[0]);
                chk("wlast", wlast, 32'(m_beat == int'(m_wlen[0])));
                m_beat++;
                n_w++;
            end
        end

        if (arvalid && arready && m_arid.size() > 0) begin
            chk("arid", arid, m_arid[0]);
            chk("araddr", araddr, m_araddr[0]);
            chk("arlen", arlen, m_arlen[0]);
            chk("arsize", arsize, m_arsize[0]);
            $display("AR id=%0d addr=%h len=%0d", arid, araddr, arlen);
            void'(m_arid.pop_front());
            void'(m_araddr.pop_front());
            void'(m_arlen.pop_front());
            void'(m_arsize.pop_front());
        end
        if (exp_drdy) begin
            m_arid.push_back(4'd1);
            m_araddr.push_back(d_rd_addr);
            m_arlen.push_back(d_rd_type == 3'b100 ? 8'(LW - 1) : 8'd0);
            m_arsize.push_back(d_rd_type == 3'b100 ? 3'b010 : d_rd_type);
        end else if (i_rd_req && exp_irdy) begin
            m_arid.push_back(4'd0);
            m_araddr.push_back(i_rd_addr);
            m_arlen.push_back(i_rd_type == 3'b100 ? 8'(LW - 1) : 8'd0);
            m_arsize.push_back(i_rd_type == 3'b100 ? 3'b010 : i_rd_type);
        end

        if (bvalid && bready) begin
            if (m_waddr.size() == 0) begin
                chk("bready_idle", bready, 0);
            end else begin
                $display("B  addr=%h beats=%0d", m_waddr[0], m_beat);
                void'(m_waddr.pop_front());
                void'(m_wlen.pop_front());
                void'(m_wsize.pop_front());
                void'(m_wstrb.pop_front());
                void'(m_wdata.pop_front());
                m_beat = 0;
                n_b++;
            end
        end
        if (enq_exp) begin
            m_waddr.push_back(d_wr_addr);
            m_wlen.push_back(d_wr_type == 3'b100 ? 8'(LW - 1) : 8'd0);
            m_wsize.push_back(d_wr_type == 3'b100 ? 3'b010 : d_wr_type);
            m_wstrb.push_back(d_wr_type == 3'b100 ? 4'hf : d_wr_wstrb);
            m_wdata.push_back(d_wr_data);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            m_waddr.delete(); m_wlen.delete(); m_wsize.delete(); m_wstrb.delete(); m_wdata.delete();
            m_arid.delete(); m_araddr.delete(); m_arlen.delete(); m_arsize.delete();
            m_beat = 0;
        end else begin
            compare_cycle();
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [LW*32-1:0] make_line(input logic [31:0] base);
        logic [LW*32-1:0] l;
        for (int j = 0; j < LW; j++) l[j*32 +: 32] = base | 32'(j);
        return l;
    endfunction

    // R-channel vectors: rid, rdata, rlast, expected icache/dcache valid
    logic [3:0]  rv_id   [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd3};
    logic [31:0] rv_data [5] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    logic        rv_last [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        rv_iexp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 4'd1; bresp = 0;
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = '0;
        reset = 1;
        repeat (3) tick();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_i_rd_rdy", i_rd_rdy, 0);
        chk("rst_d_wr_rdy", d_wr_rdy, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wb_empty", write_buffer_empty, 1);
        reset = 0;
        tick();

        // Fill the buffer with the slave stalled; the fifth write must be refused
        for (int k = 0; k < 5; k++) begin
            d_wr_req  = 1; d_wr_type = 3'b100;
            d_wr_addr = 32'h2000_0000 + 32'(k * 16);
            d_wr_data = make_line(32'hA000_0000 | 32'(k << 8));
            #1 chk($sformatf("t1_wr_rdy_%0d", k), d_wr_rdy, (k < 4) ? 1 : 0);
            tick();
        end
        d_wr_req = 0;
        awready = 1; wready = 1; bvalid = 1;
        for (int c = 0; c < 200 && !write_buffer_empty; c++) tick();
        chk("t1_empty", write_buffer_empty, 1);
        chk("t1_aw_count", n_aw, 4);
        chk("t1_w_beats", n_w, 16);
        chk("t1_b_count", n_b, 4);

        // RAW: a same-cycle write and every later cycle until the B response block the read
        bvalid = 0;
        d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h1000_0040;
        d_wr_data = make_line(32'hB000_0000);
        d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h1000_0048;
        #1 chk("t2_raw_same_cycle", d_rd_rdy, 0);
        tick();
        d_wr_req = 0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t2_raw_block_%0d", c), d_rd_rdy, 0);
            tick();
        end
        chk("t2_wait_b", bready, 1);
        bvalid = 1;
        chk("t2_block_pop_cycle", d_rd_rdy, 0);
        tick();
        bvalid = 0;
        chk("t2_unblocked", d_rd_rdy, 1);
        tick();
        d_rd_req = 0;
        chk("t2_arvalid", arvalid, 1);
        chk("t2_araddr", araddr, 32'h1000_0048);
        chk("t2_arlen", arlen, 3);
        chk("t2_arid", arid, 1);
        arready = 1;
        tick();
        arready = 0;
        chk("t2_ar_done", arvalid, 0);

        // Arbitration: dcache first, icache on the following arready
        d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h3000_0000;
        i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h4000_0010;
        #1 chk("t3_d_grant", d_rd_rdy, 1);
        chk("t3_i_wait", i_rd_rdy, 0);
        tick();
        d_rd_req = 0;
        #1 chk("t3_i_busy", i_rd_rdy, 0);
        chk("t3_arid_d", arid, 1);
        arready = 1;
        #1 chk("t3_i_grant", i_rd_rdy, 1);
        tick();
        i_rd_req = 0;
        chk("t3_arid_i", arid, 0);
        chk("t3_araddr_i", araddr, 32'h4000_0010);
        tick();
        arready = 0;
        chk("t3_ar_idle", arvalid, 0);

        // Single byte write
        awready = 1; wready = 1; bvalid = 0;
        d_wr_req = 1; d_wr_type = 3'b000; d_wr_addr = 32'h5000_0003; d_wr_wstrb = 4'b0010;
        d_wr_data = '0;
        d_wr_data[31:0] = 32'hAABB_CCDD;
        tick();
        d_wr_req = 0;
        for (int c = 0; c < 10 && !awvalid; c++) tick();
        chk("t4_awvalid", awvalid, 1);
        chk("t4_awlen", awlen, 0);
        chk("t4_awsize", awsize, 0);
        tick();
        chk("t4_wvalid", wvalid, 1);
        chk("t4_wlast", wlast, 1);
        chk("t4_wstrb", wstrb, 4'b0010);
        chk("t4_wdata", wdata, 32'hAABB_CCDD);
        tick();
        chk("t4_bready", bready, 1);
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("t4_empty", write_buffer_empty, 1);

        // Interleaved read returns
        for (int v = 0; v < 5; v++) begin
            rvalid = 1; rid = rv_id[v]; rdata = rv_data[v]; rlast = rv_last[v];
            #1 chk($sformatf("t5_i_valid_%0d", v), i_ret_valid, rv_iexp[v]);
            chk($sformatf("t5_d_valid_%0d", v), d_ret_valid, !rv_iexp[v]);
            chk($sformatf("t5_data_%0d", v), rv_iexp[v] ? i_ret_data : d_ret_data, rv_data[v]);
            chk($sformatf("t5_last_%0d", v), rv_iexp[v] ? i_ret_last : d_ret_last, rv_last[v]);
            $display("R  id=%0d data=%h last=%0d", rid, rdata, rlast);
            tick();
        end
        rvalid = 0; rlast = 0;

        // Reset in the middle of a burst, on beat 2
        awready = 1; wready = 1; bvalid = 0;
        d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h6000_0000;
        d_wr_data = make_line(32'h6000_0000);
        tick();
        d_wr_req = 0;
        for (int c = 0; c < 10 && !wvalid; c++) tick();
        tick();
        tick();
        chk("t6_beat2", wdata, 32'h6000_0002);
        reset = 1;
        #1 chk("t6_wvalid", wvalid, 0);
        chk("t6_bready", bready, 0);
        chk("t6_empty", write_buffer_empty, 1);
        tick();
        reset = 0;
        #1 chk("t6_wr_rdy", d_wr_rdy, 1);
        chk("t6_empty_after", write_buffer_empty, 1);
        repeat (3) tick();
        chk("t6_no_stale_aw", awvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
